ace_snoop_gen: RTL and testbench

ACE_SNOOP_GEN -- requirements
Module: ace_snoop_gen

---
 rtl/ariane_ace.sv | 32 +++
 rtl/ace_snoop_gen.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_ace_snoop_gen.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ariane_ace.sv
// Snoop-channel structs shared by the snoop generator and its caches.
// Pure type definitions, no logic or latency.
// Request side carries the AC channel plus the CR/CD readies; response side carries the rest.
package ariane_ace;

    typedef struct packed {
        logic [63:0] addr;
        logic [3:0]  snoop;
        logic [2:0]  prot;
    } ac_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } cd_chan_t;

    typedef struct packed {
        logic     ac_valid;
        ac_chan_t ac;
        logic     cr_ready;
        logic     cd_ready;
    } snoop_req_t;

    typedef struct packed {
        logic     ac_ready;
        logic     cr_valid;
        logic [4:0] cr_resp;
        logic     cd_valid;
        cd_chan_t cd;
    } snoop_resp_t;

endpackage

// File: rtl/ace_snoop_gen.sv
// Pseudo-random ACE snoop generator: drives AC, collects CR and CD from NrPorts caches.
// One snoop in flight at a time; each phase waits for every targeted port before moving on.
// AC valid held stable until ac_ready; cr_ready/cd_ready only on targeted ports; a watchdog ends stuck runs.
module ace_snoop_gen #(
    parameter int unsigned NrPorts       = 2,
    parameter int unsigned AddrWidth     = 64,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned LineBytes     = 16,
    parameter logic [63:0] AddrBase      = 64'h0,
    parameter logic [63:0] AddrLen       = 64'h1000,
    parameter logic [31:0] LfsrSeed      = 32'hACE1_0001,
    parameter int unsigned TimeoutCycles = 1024,
    parameter type         snoop_req_t   = ariane_ace::snoop_req_t,
    parameter type         snoop_resp_t  = ariane_ace::snoop_resp_t
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic                      mode_i,
    input  logic [31:0]               num_snoops_i,
    input  logic [5:0]                snoop_en_i,
    output snoop_req_t  [NrPorts-1:0] snoop_req_o,
    input  snoop_resp_t [NrPorts-1:0] snoop_resp_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o,
    output logic                      timeout_o,
    output logic [31:0]               issued_cnt_o,
    output logic [31:0]               data_cnt_o
);

    localparam int unsigned BeatsRaw = (LineBytes * 8) / DataWidth;
    localparam int unsigned Beats    = (BeatsRaw > 0) ? BeatsRaw : 1;
    localparam int unsigned BeatW    = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int unsigned PtrW     = (NrPorts > 1) ? $clog2(NrPorts) : 1;

    localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);
    localparam logic [PtrW-1:0]  LastPort = PtrW'(NrPorts - 1);
    localparam logic [31:0]      PhaseLim = 32'(TimeoutCycles) - 32'd1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT_CR = 3'd2;
    localparam logic [2:0] S_WAIT_CD = 3'd3;
    localparam logic [2:0] S_NEXT    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    // Galois step for x^32+x^22+x^2+x+1 (right-shifting form).
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    logic [2:0]                    state_q, state_d;
    logic [31:0]                   phase_q, phase_d;
    logic                          mode_q, mode_d;
    logic [31:0]                   num_q, num_d;
    logic [5:0]                    en_q, en_d;
    logic [PtrW-1:0]               rr_q, rr_d;
    logic [31:0]                   lfsr_q, lfsr_d;
    logic [31:0]                   issued_q, issued_d;
    logic [31:0]                   data_q, data_d;
    logic                          err_q, err_d;
    logic                          to_q, to_d;
    logic [NrPorts-1:0]            ac_done_q, ac_done_d;
    logic [NrPorts-1:0]            cr_done_q, cr_done_d;
    logic [NrPorts-1:0]            dt_q, dt_d;
    logic [NrPorts-1:0]            cd_done_q, cd_done_d;
    logic [NrPorts-1:0][BeatW-1:0] beat_q, beat_d;

    logic [NrPorts-1:0] tgt;
    logic [NrPorts-1:0] ac_hs, cr_hs, cd_hs;
    logic [NrPorts-1:0] cr_dt, cr_err, cd_last_in, last_beat;
    logic [NrPorts-1:0] dt_new;
    logic [NrPorts-1:0] unused_resp;
    logic               all_ac, all_cr, all_cd, timeout_hit;
    logic [63:0]        addr_off;
    logic [AddrWidth-1:0] ac_addr;
    logic [3:0]         ac_snoop;
    logic [2:0]         cand;
    logic [2:0]         type_idx;
    logic [3:0]         idx;
    logic               found;
    logic [32:0]        data_sum;

    // Snoop address and type are pure functions of the current LFSR value, so they hold still until NEXT.
    always_comb begin
        addr_off = {32'h0, lfsr_q} & (AddrLen - 64'd1) & ~(64'(LineBytes) - 64'd1);
        ac_addr  = AddrWidth'(AddrBase + addr_off);
        cand     = (lfsr_q[31:29] >= 3'd6) ? (lfsr_q[31:29] - 3'd6) : lfsr_q[31:29];
        type_idx = 3'd0;
        found    = 1'b0;
        idx      = 4'd0;
        for (int k = 0; k < 6; k++) begin
            idx = {1'b0, cand} + 4'(k);
            if (idx >= 4'd6) idx = idx - 4'd6;
            if (!found && en_q[idx[2:0]]) begin
                type_idx = idx[2:0];
                found    = 1'b1;
            end
        end
        case (type_idx)
            3'd0:    ac_snoop = 4'b0000;
            3'd1:    ac_snoop = 4'b0001;
            3'd2:    ac_snoop = 4'b0111;
            3'd3:    ac_snoop = 4'b1000;
            3'd4:    ac_snoop = 4'b1001;
            3'd5:    ac_snoop = 4'b1101;
            default: ac_snoop = 4'b0000;
        endcase
    end

    // Target mask and per-port handshake detection.
    always_comb begin
        tgt = mode_q ? {NrPorts{1'b1}} : (NrPorts'(1) << rr_q);
        for (int p = 0; p < NrPorts; p++) begin
            ac_hs[p]      = (state_q == S_ISSUE) && tgt[p] && !ac_done_q[p] && snoop_resp_i[p].ac_ready;
            cr_hs[p]      = (state_q == S_WAIT_CR) && tgt[p] && !cr_done_q[p] && snoop_resp_i[p].cr_valid;
            cd_hs[p]      = (state_q == S_WAIT_CD) && tgt[p] && dt_q[p] && !cd_done_q[p]
                            && snoop_resp_i[p].cd_valid;
            cr_dt[p]      = snoop_resp_i[p].cr_resp[0];
            cr_err[p]     = snoop_resp_i[p].cr_resp[1];
            cd_last_in[p] = snoop_resp_i[p].cd.last;
            last_beat[p]  = (beat_q[p] == LastBeat);
            // Data payload is only counted, never stored; upper CR bits carry no meaning here.
            unused_resp[p] = ^{snoop_resp_i[p].cr_resp[4:2], snoop_resp_i[p].cd.data};
        end
        dt_new      = dt_q | (cr_hs & cr_dt);
        all_ac      = &(ac_done_q | ac_hs | ~tgt);
        all_cr      = &(cr_done_q | cr_hs | ~tgt);
        all_cd      = &(cd_done_q | (cd_hs & last_beat) | ~(tgt & dt_q));
        timeout_hit = (phase_q >= PhaseLim);
        data_sum    = {1'b0, data_q} + 33'($countones(cd_hs));
    end

    // Run sequencing: next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        num_d     = num_q;
        en_d      = en_q;
        rr_d      = rr_q;
        lfsr_d    = lfsr_q;
        issued_d  = issued_q;
        data_d    = data_q;
        err_d     = err_q;
        to_d      = to_q;
        ac_done_d = ac_done_q;
        cr_done_d = cr_done_q;
        dt_d      = dt_q;
        cd_done_d = cd_done_q;
        beat_d    = beat_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    mode_d    = mode_i;
                    num_d     = num_snoops_i;
                    en_d      = snoop_en_i;
                    rr_d      = '0;
                    issued_d  = '0;
                    data_d    = '0;
                    err_d     = 1'b0;
                    to_d      = 1'b0;
                    ac_done_d = '0;
                    state_d   = (num_snoops_i == 32'd0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                ac_done_d = ac_done_q | ac_hs;
                if (all_ac) begin
                    state_d   = S_WAIT_CR;
                    cr_done_d = '0;
                    dt_d      = '0;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    to_d    = 1'b1;
                    err_d   = 1'b1;
                end
            end
            S_WAIT_CR: begin
                cr_done_d = cr_done_q | cr_hs;
                dt_d      = dt_new;
                if (|(cr_hs & cr_err)) err_d = 1'b1;
                if (all_cr) begin
                    if (|dt_new) begin
                        state_d   = S_WAIT_CD;
                        cd_done_d = '0;
                        beat_d    = '0;
                    end else begin
                        state_d = S_NEXT;
                        lfsr_d  = lfsr_next(lfsr_q);
                    end
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    to_d    = 1'b1;
                    err_d   = 1'b1;
                end
            end
            S_WAIT_CD: begin
                for (int p = 0; p < NrPorts; p++) begin
                    if (cd_hs[p]) begin
                        if (cd_last_in[p] != last_beat[p]) err_d = 1'b1;
                        if (last_beat[p]) cd_done_d[p] = 1'b1;
                        else              beat_d[p]    = beat_q[p] + BeatW'(1);
                    end
                end
                data_d = data_sum[32] ? 32'hFFFF_FFFF : data_sum[31:0];
                if (all_cd) begin
                    state_d = S_NEXT;
                    lfsr_d  = lfsr_next(lfsr_q);
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    to_d    = 1'b1;
                    err_d   = 1'b1;
                end
            end
            S_NEXT: begin
                if (issued_q != 32'hFFFF_FFFF) issued_d = issued_q + 32'd1;
                rr_d = (rr_q == LastPort) ? '0 : (rr_q + PtrW'(1));
                if (({1'b0, issued_q} + 33'd1) == {1'b0, num_q}) begin
                    state_d = S_DONE;
                end else begin
                    state_d   = S_ISSUE;
                    ac_done_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Phase counter restarts on every state change; saturates so it never wraps.
        if (state_d != state_q)          phase_d = '0;
        else if (phase_q == 32'hFFFF_FFFF) phase_d = phase_q;
        else                             phase_d = phase_q + 32'd1;
    end

    // State registers; reset aborts any in-flight handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            mode_q    <= 1'b0;
            num_q     <= '0;
            en_q      <= '0;
            rr_q      <= '0;
            lfsr_q    <= LfsrSeed;
            issued_q  <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            to_q      <= 1'b0;
            ac_done_q <= '0;
            cr_done_q <= '0;
            dt_q      <= '0;
            cd_done_q <= '0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            mode_q    <= mode_d;
            num_q     <= num_d;
            en_q      <= en_d;
            rr_q      <= rr_d;
            lfsr_q    <= lfsr_d;
            issued_q  <= issued_d;
            data_q    <= data_d;
            err_q     <= err_d;
            to_q      <= to_d;
            ac_done_q <= ac_done_d;
            cr_done_q <= cr_done_d;
            dt_q      <= dt_d;
            cd_done_q <= cd_done_d;
            beat_q    <= beat_d;
        end
    end

    // Channel outputs: valids/readies decoded from state so they drop the moment the state leaves.
    always_comb begin
        for (int p = 0; p < NrPorts; p++) begin
            snoop_req_o[p]          = '0;
            snoop_req_o[p].ac.addr  = ac_addr;
            snoop_req_o[p].ac.snoop = ac_snoop;
            snoop_req_o[p].ac.prot  = 3'b000;
            snoop_req_o[p].ac_valid = (state_q == S_ISSUE) && tgt[p] && !ac_done_q[p];
            snoop_req_o[p].cr_ready = (state_q == S_WAIT_CR) && tgt[p] && !cr_done_q[p];
            snoop_req_o[p].cd_ready = (state_q == S_WAIT_CD) && tgt[p] && dt_q[p] && !cd_done_q[p];
        end
    end

    assign busy_o       = (state_q == S_ISSUE) || (state_q == S_WAIT_CR) ||
                          (state_q == S_WAIT_CD) || (state_q == S_NEXT);
    assign done_o       = (state_q == S_DONE);
    assign error_o      = err_q;
    assign timeout_o    = to_q;
    assign issued_cnt_o = issued_q;
    assign data_cnt_o   = data_q;

endmodule

// File: tb/tb_ace_snoop_gen.sv
module tb_ace_snoop_gen;

    localparam int          NP    = 2;
    localparam int          TO    = 40;
    localparam int          BEATS = 2;
    localparam logic [31:0] SEED  = 32'hACE1_0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        mode;
    logic [31:0] num;
    logic [5:0]  en;
    ariane_ace::snoop_req_t  [NP-1:0] req;
    ariane_ace::snoop_resp_t [NP-1:0] resp;
    logic        busy, done, error, tmo;
    logic [31:0] issued, dcnt;

    ace_snoop_gen #(
        .NrPorts      (NP),
        .AddrWidth    (64),
        .DataWidth    (64),
        .LineBytes    (16),
        .AddrBase     (64'h0),
        .AddrLen      (64'h1000),
        .LfsrSeed     (SEED),
        .TimeoutCycles(TO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .mode_i      (mode),
        .num_snoops_i(num),
        .snoop_en_i  (en),
        .snoop_req_o (req),
        .snoop_resp_i(resp),
        .busy_o      (busy),
        .done_o      (done),
        .error_o     (error),
        .timeout_o   (tmo),
        .issued_cnt_o(issued),
        .data_cnt_o  (dcnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int          port;
        logic [63:0] addr;
        logic [3:0]  snp;
    } exp_t;
    exp_t sb[$];

    // Responder configuration, set by the directed sequence.
    logic       ac_en;
    int         ac_delay [NP];
    logic [4:0] cr_cfg   [NP];
    logic       bad_last;
    logic       cd_hold;

    // Responder/monitor bookkeeping.
    int          ac_wait [NP];
    int          beat    [NP];
    logic        ac_seen [NP];
    logic [63:0] seen_addr [NP];
    logic [3:0]  seen_snp  [NP];
    int          hs_cnt  [NP];
    int          cd_cnt  [NP];
    int          cr_phases;
    logic        cr_any_prev;
    logic        cr_any;
    exp_t        e;

    logic [NP-1:0] acv, crr, cdr;
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            acv[p] = req[p].ac_valid;
            crr[p] = req[p].cr_ready;
            cdr[p] = req[p].cd_ready;
        end
    end

    // Cache model: answers AC/CR/CD and scores every AC handshake against the expected queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < NP; p++) begin
                resp[p]    = '0;
                ac_wait[p] = 0;
                beat[p]    = 0;
                ac_seen[p] = 1'b0;
            end
            cr_any_prev = 1'b0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (req[p].ac_valid) begin
                    if (ac_seen[p]) begin
                        chk("ac_addr_stable", req[p].ac.addr, seen_addr[p]);
                        chk("ac_snoop_stable", {60'h0, req[p].ac.snoop}, {60'h0, seen_snp[p]});
                    end
                    ac_seen[p]   = 1'b1;
                    seen_addr[p] = req[p].ac.addr;
                    seen_snp[p]  = req[p].ac.snoop;
                    resp[p].ac_ready = ac_en && (ac_wait[p] >= ac_delay[p]);
                    ac_wait[p]++;
                    if (resp[p].ac_ready) begin
                        hs_cnt[p]++;
                        ac_seen[p] = 1'b0;
                        chk("ac_expected_avail", 64'(sb.size() > 0), 64'd1);
                        if (sb.size() > 0) begin
                            e = sb.pop_front();
                            chk("ac_port", 64'(p), 64'(e.port));
                            chk("ac_addr", req[p].ac.addr, e.addr);
                            chk("ac_snoop", {60'h0, req[p].ac.snoop}, {60'h0, e.snp});
                            chk("ac_prot", {61'h0, req[p].ac.prot}, 64'h0);
                        end
                    end
                end else begin
                    resp[p].ac_ready = 1'b0;
                    ac_wait[p]       = 0;
                    ac_seen[p]       = 1'b0;
                end
                resp[p].cr_valid = req[p].cr_ready;
                resp[p].cr_resp  = cr_cfg[p];
                if (req[p].cd_ready && !cd_hold) begin
                    resp[p].cd_valid   = 1'b1;
                    resp[p].cd.data    = 64'(beat[p]);
                    resp[p].cd.last    = bad_last ? (beat[p] == 0) : (beat[p] == BEATS - 1);
                    beat[p]++;
                    cd_cnt[p]++;
                end else begin
                    resp[p].cd_valid = 1'b0;
                    resp[p].cd.last  = 1'b0;
                    if (!req[p].cd_ready) beat[p] = 0;
                end
            end
            cr_any = |crr;
            if (cr_any && !cr_any_prev) cr_phases++;
            cr_any_prev = cr_any;
        end
    end

    // Reference model of the snoop stream.
    logic [31:0] m_lfsr;
    int          m_rr;

    function automatic logic [31:0] m_step(input logic [31:0] v);
        logic [31:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    function automatic logic [3:0] m_type(input logic [31:0] v, input logic [5:0] msk);
        logic [3:0] enc [6];
        int c, i;
        enc[0] = 4'b0000; enc[1] = 4'b0001; enc[2] = 4'b0111;
        enc[3] = 4'b1000; enc[4] = 4'b1001; enc[5] = 4'b1101;
        if (msk == 6'd0) return 4'b0000;
        c = int'(v[31:29]) % 6;
        for (int k = 0; k < 6; k++) begin
            i = (c + k) % 6;
            if (msk[i]) return enc[i];
        end
        return 4'b0000;
    endfunction

    task automatic plan(input logic md, input int n, input logic [5:0] msk);
        exp_t x;
        m_rr = 0;
        for (int s = 0; s < n; s++) begin
            x.addr = {32'h0, m_lfsr} & 64'hFF0;
            x.snp  = m_type(m_lfsr, msk);
            if (md) begin
                for (int p = 0; p < NP; p++) begin
                    x.port = p;
                    sb.push_back(x);
                end
            end else begin
                x.port = m_rr;
                sb.push_back(x);
            end
            m_rr   = (m_rr + 1) % NP;
            m_lfsr = m_step(m_lfsr);
        end
    endtask

    task automatic pulse_start(input logic md, input int n, input logic [5:0] msk);
        @(negedge clk);
        mode  = md;
        num   = n;
        en    = msk;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_within_budget", {63'h0, done}, 64'd1);
    endtask

    task automatic run(input logic md, input int n, input logic [5:0] msk);
        plan(md, n, msk);
        pulse_start(md, n, msk);
        wait_done(400);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic clear_stats();
        for (int p = 0; p < NP; p++) begin
            hs_cnt[p] = 0;
            cd_cnt[p] = 0;
        end
        cr_phases = 0;
    endtask

    int hs_before;
    int k;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        mode     = 1'b0;
        num      = 32'd0;
        en       = 6'd0;
        resp     = '0;
        ac_en    = 1'b1;
        bad_last = 1'b0;
        cd_hold  = 1'b0;
        for (int p = 0; p < NP; p++) begin
            ac_delay[p] = 0;
            cr_cfg[p]   = 5'd0;
        end
        clear_stats();
        m_lfsr = SEED;
        m_rr   = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'h0, busy}, 64'd0);
        chk("rst_done", {63'h0, done}, 64'd0);
        chk("rst_error", {63'h0, error}, 64'd0);
        chk("rst_timeout", {63'h0, tmo}, 64'd0);
        chk("rst_issued", {32'h0, issued}, 64'd0);
        chk("rst_data", {32'h0, dcnt}, 64'd0);
        chk("rst_ac_valid", 64'(acv), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Round robin, four snoops, no data
        clear_stats();
        run(1'b0, 4, 6'h3F);
        chk("rr_issued", {32'h0, issued}, 64'd4);
        chk("rr_error", {63'h0, error}, 64'd0);
        chk("rr_data", {32'h0, dcnt}, 64'd0);
        chk("rr_port0_hs", 64'(hs_cnt[0]), 64'd2);
        chk("rr_port1_hs", 64'(hs_cnt[1]), 64'd2);
        chk("rr_busy_after", {63'h0, busy}, 64'd0);

        // Broadcast with port 1 accepting five cycles late
        clear_stats();
        ac_delay[1] = 5;
        run(1'b1, 1, 6'h3F);
        ac_delay[1] = 0;
        chk("bc_issued", {32'h0, issued}, 64'd1);
        chk("bc_cr_phases", 64'(cr_phases), 64'd1);
        chk("bc_port1_hs", 64'(hs_cnt[1]), 64'd1);

        // Broadcast with data from port 0
        clear_stats();
        cr_cfg[0] = 5'b00001;
        run(1'b1, 1, 6'h3F);
        chk("cd_data_cnt", {32'h0, dcnt}, 64'd2);
        chk("cd_error", {63'h0, error}, 64'd0);
        chk("cd_port0_beats", 64'(cd_cnt[0]), 64'd2);
        chk("cd_port1_beats", 64'(cd_cnt[1]), 64'd0);

        // Same, with last on the wrong beat
        bad_last = 1'b1;
        run(1'b1, 1, 6'h3F);
        bad_last  = 1'b0;
        cr_cfg[0] = 5'd0;
        chk("badlast_error", {63'h0, error}, 64'd1);
        chk("badlast_issued", {32'h0, issued}, 64'd1);
        chk("badlast_data", {32'h0, dcnt}, 64'd2);

        // Enable masks: single type, none enabled, sparse
        run(1'b0, 3, 6'b100000);
        chk("mask_mi_error", {63'h0, error}, 64'd0);
        run(1'b0, 4, 6'b000000);
        chk("mask_none_issued", {32'h0, issued}, 64'd4);
        run(1'b0, 5, 6'b010010);
        chk("mask_sparse_issued", {32'h0, issued}, 64'd5);

        // Error response on CR
        cr_cfg[1] = 5'b00010;
        run(1'b0, 2, 6'h3F);
        cr_cfg[1] = 5'd0;
        chk("crerr_error", {63'h0, error}, 64'd1);
        chk("crerr_timeout", {63'h0, tmo}, 64'd0);
        chk("crerr_issued", {32'h0, issued}, 64'd2);

        // Watchdog: AC never accepted
        ac_en = 1'b0;
        pulse_start(1'b0, 2, 6'h3F);
        repeat (TO - 1) @(negedge clk);
        chk("to_still_busy", {63'h0, busy}, 64'd1);
        chk("to_not_done_early", {63'h0, done}, 64'd0);
        @(negedge clk);
        chk("to_done", {63'h0, done}, 64'd1);
        chk("to_timeout", {63'h0, tmo}, 64'd1);
        chk("to_error", {63'h0, error}, 64'd1);
        chk("to_busy", {63'h0, busy}, 64'd0);
        chk("to_ac_valid", 64'(acv), 64'd0);
        chk("to_issued", {32'h0, issued}, 64'd0);
        ac_en = 1'b1;

        // Reset while waiting for data
        cr_cfg[0] = 5'b00001;
        cd_hold   = 1'b1;
        plan(1'b1, 1, 6'h3F);
        pulse_start(1'b1, 1, 6'h3F);
        k = 0;
        while (!req[0].cd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("cdwait_reached", {63'h0, req[0].cd_ready}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'h0, busy}, 64'd0);
        chk("arst_done", {63'h0, done}, 64'd0);
        chk("arst_error", {63'h0, error}, 64'd0);
        chk("arst_issued", {32'h0, issued}, 64'd0);
        chk("arst_data", {32'h0, dcnt}, 64'd0);
        chk("arst_ac_valid", 64'(acv), 64'd0);
        chk("arst_cr_ready", 64'(crr), 64'd0);
        chk("arst_cd_ready", 64'(cdr), 64'd0);
        chk("arst_sb_drained", 64'(sb.size()), 64'd0);
        m_lfsr = SEED;
        @(negedge clk);
        rst_n     = 1'b1;
        cd_hold   = 1'b0;
        cr_cfg[0] = 5'd0;

        // Zero-length run
        hs_before = hs_cnt[0] + hs_cnt[1];
        pulse_start(1'b0, 0, 6'h3F);
        chk("zero_done", {63'h0, done}, 64'd1);
        chk("zero_busy", {63'h0, busy}, 64'd0);
        @(negedge clk);
        chk("zero_no_ac", 64'(hs_cnt[0] + hs_cnt[1]), 64'(hs_before));
        chk("zero_issued", {32'h0, issued}, 64'd0);

        // First snoops after reset follow the seed again
        run(1'b0, 2, 6'h3F);
        chk("reseed_issued", {32'h0, issued}, 64'd2);
        chk("reseed_error", {63'h0, error}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
